// File: rtl/time_display_scanner_if.sv
// rtl/time_display_scanner_if.sv - time/set-mode inputs and multiplexed segment outputs
//
// Purpose: bundles the display-side signals between the HH:MM:SS timekeeper
//          (master) and the multiplexed 7-segment scanner (slave).
// Signals:
//   power_state  1 = display on, 0 = dark with scan held
//   set_mode     1 = time-setting mode, enables blinking of the edited field
//   set_select   edited field: 0 = minutes, 1 = hours
//   hours        binary hours 0..23
//   minutes      binary minutes 0..59
//   seconds      binary seconds 0..59
//   seg_out      segments {a,b,c,d,e,f,g,dp}, active-high
//   digit_sel    one-hot digit enable, bit7 = leftmost digit
interface time_display_scanner_if;
  logic       power_state;
  logic       set_mode;
  logic       set_select;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [7:0] seg_out;
  logic [7:0] digit_sel;

  modport master (
    output power_state, set_mode, set_select, hours, minutes, seconds,
    input  seg_out, digit_sel
  );

  modport slave (
    input  power_state, set_mode, set_select, hours, minutes, seconds,
    output seg_out, digit_sel
  );
endinterface

// File: rtl/time_display_scanner.sv
// rtl/time_display_scanner.sv - multiplexed 8-digit HH-MM-SS 7-segment scanner
//
// Purpose: scans "HH-MM-SS" onto a shared segment bus, one digit per SCAN_DIV
//          cycles. Time is snapshotted once per frame; the field being edited
//          blinks with a BLINK_DIV half-period while set_mode is high.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   disp   slave side of time_display_scanner_if (time/mode in, seg/digit out)
module time_display_scanner #(
  parameter logic [31:0] SCAN_DIV  = 32'd100000,
  parameter logic [31:0] BLINK_DIV = 32'd25000000
) (
  input logic                  clk,
  input logic                  reset,
  time_display_scanner_if.slave disp
);

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_E     = 4'd11;
  localparam logic [3:0] CODE_BLANK = 4'd12;

  logic [31:0] scan_cnt_q, scan_cnt_d;
  logic [31:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        blink_on_q, blink_on_d;
  logic [4:0]  snap_h_q, snap_h_d;
  logic [5:0]  snap_m_q, snap_m_d;
  logic [5:0]  snap_s_q, snap_s_d;
  logic [7:0]  seg_q, seg_d;
  logic [7:0]  dsel_q, dsel_d;

  logic [5:0]  fval;
  logic        fbad;
  logic        fblinkable;
  logic [5:0]  tens;
  logic [5:0]  units;
  logic [3:0]  code;

  function automatic logic [7:0] glyph(input logic [3:0] c);
    case (c)
      4'd0:    glyph = 8'hFC;
      4'd1:    glyph = 8'h60;
      4'd2:    glyph = 8'hDA;
      4'd3:    glyph = 8'hF2;
      4'd4:    glyph = 8'h66;
      4'd5:    glyph = 8'hB6;
      4'd6:    glyph = 8'hBE;
      4'd7:    glyph = 8'hE0;
      4'd8:    glyph = 8'hFE;
      4'd9:    glyph = 8'hF6;
      4'd10:   glyph = 8'h02;
      4'd11:   glyph = 8'h9E;
      default: glyph = 8'h00;
    endcase
  endfunction

  // Digit code for the digit currently addressed by idx_q.
  always_comb begin
    fval       = '0;
    fbad       = 1'b0;
    fblinkable = 1'b0;
    code       = CODE_BLANK;
    case (idx_q)
      3'd0, 3'd1: begin
        fval       = {1'b0, snap_h_q};
        fbad       = snap_h_q > 5'd23;
        fblinkable = disp.set_select;
      end
      3'd3, 3'd4: begin
        fval       = snap_m_q;
        fbad       = snap_m_q > 6'd59;
        fblinkable = !disp.set_select;
      end
      3'd6, 3'd7: begin
        fval = snap_s_q;
        fbad = snap_s_q > 6'd59;
      end
      default: ;
    endcase
    tens  = fval / 6'd10;
    units = fval % 6'd10;
    if (idx_q == 3'd2 || idx_q == 3'd5) begin
      code = CODE_DASH;
    end else if (disp.set_mode && !blink_on_q && fblinkable) begin
      // Gated by set_mode so dropping set_mode shows the field immediately.
      code = CODE_BLANK;
    end else if (fbad) begin
      code = CODE_E;
    end else if (idx_q == 3'd0 || idx_q == 3'd3 || idx_q == 3'd6) begin
      code = tens[3:0];
    end else begin
      code = units[3:0];
    end
  end

  always_comb begin
    scan_cnt_d  = scan_cnt_q;
    blink_cnt_d = blink_cnt_q;
    idx_d       = idx_q;
    blink_on_d  = blink_on_q;
    snap_h_d    = snap_h_q;
    snap_m_d    = snap_m_q;
    snap_s_d    = snap_s_q;
    seg_d       = 8'h00;
    dsel_d      = 8'h00;
    if (!disp.power_state) begin
      scan_cnt_d  = '0;
      idx_d       = '0;
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else begin
      seg_d  = glyph(code);
      dsel_d = 8'h80 >> idx_q;
      if (scan_cnt_q == SCAN_DIV - 32'd1) begin
        scan_cnt_d = '0;
        idx_d      = idx_q + 3'd1;
        // Capture at the frame boundary so a frame never mixes two times.
        if (idx_q == 3'd7) begin
          snap_h_d = disp.hours;
          snap_m_d = disp.minutes;
          snap_s_d = disp.seconds;
        end
      end else begin
        scan_cnt_d = scan_cnt_q + 32'd1;
      end
      if (!disp.set_mode) begin
        blink_cnt_d = '0;
        blink_on_d  = 1'b1;
      end else if (blink_cnt_q == BLINK_DIV - 32'd1) begin
        blink_cnt_d = '0;
        blink_on_d  = !blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      idx_q       <= '0;
      blink_on_q  <= 1'b1;
      snap_h_q    <= '0;
      snap_m_q    <= '0;
      snap_s_q    <= '0;
      seg_q       <= 8'h00;
      dsel_q      <= 8'h00;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      idx_q       <= idx_d;
      blink_on_q  <= blink_on_d;
      snap_h_q    <= snap_h_d;
      snap_m_q    <= snap_m_d;
      snap_s_q    <= snap_s_d;
      seg_q       <= seg_d;
      dsel_q      <= dsel_d;
    end
  end

  assign disp.seg_out   = seg_q;
  assign disp.digit_sel = dsel_q;

endmodule

// File: tb/tb_time_display_scanner.sv
// tb/tb_time_display_scanner.sv - scoreboard bench for time_display_scanner
module tb_time_display_scanner;
  localparam int SCAN  = 4;
  localparam int BLINK = 16;
  localparam int FRAME = 8 * SCAN;
  localparam logic [7:0] GL [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                     8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

  typedef struct packed {
    logic [7:0] dsel;
    logic [7:0] seg;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  time_display_scanner_if bus();

  time_display_scanner #(.SCAN_DIV(32'd4), .BLINK_DIV(32'd16)) dut (
    .clk   (clk),
    .reset (reset),
    .disp  (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int ncyc = 0;

  // Reference model state: powered edges since restart, consecutive
  // set-mode edges, and the time shown by the current frame.
  int pos = 0;
  int run = 0;
  int sh = 0, sm = 0, ss = 0;

  function automatic logic [7:0] exp_seg(int idx, bit bon, bit smode, bit ssel);
    int v;
    bit oor;
    bit blk;
    if (idx == 2 || idx == 5) return 8'h02;
    if (idx <= 1) begin
      v = sh; oor = (sh > 23); blk = smode && !bon && ssel;
    end else if (idx <= 4) begin
      v = sm; oor = (sm > 59); blk = smode && !bon && !ssel;
    end else begin
      v = ss; oor = (ss > 59); blk = 1'b0;
    end
    if (blk) return 8'h00;
    if (oor) return 8'h9E;
    return (idx % 3 == 0) ? GL[v / 10] : GL[v % 10];
  endfunction

  // Expected outputs for the coming rising edge, from the current inputs.
  task automatic step();
    exp_t e;
    int idx;
    bit bon;
    e = '0;
    if (!reset) begin
      pos = 0; run = 0; sh = 0; sm = 0; ss = 0;
    end else if (!bus.power_state) begin
      pos = 0; run = 0;
    end else begin
      idx = (pos / SCAN) % 8;
      bon = ((run / BLINK) % 2) == 0;
      e.dsel = 8'h80 >> idx;
      e.seg  = exp_seg(idx, bon, bus.set_mode, bus.set_select);
      if (pos % FRAME == FRAME - 1) begin
        sh = bus.hours; sm = bus.minutes; ss = bus.seconds;
      end
      pos++;
      run = bus.set_mode ? run + 1 : 0;
    end
    q.push_back(e);
  endtask

  task automatic cycle(int n = 1);
    for (int i = 0; i < n; i++) begin
      step();
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic async_reset_check();
    step();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if (bus.seg_out !== 8'h00 || bus.digit_sel !== 8'h00) begin
      bad++;
      $display("FAIL async_reset seg=%h dsel=%h required 00/00", bus.seg_out, bus.digit_sel);
    end
    pos = 0; run = 0; sh = 0; sm = 0; ss = 0;
    @(negedge clk);
  endtask

  task automatic random_time();
    if ($urandom_range(0, 5) == 0) begin
      bus.hours   = 5'($urandom_range(0, 31));
      bus.minutes = 6'($urandom_range(0, 63));
      bus.seconds = 6'($urandom_range(0, 63));
    end else begin
      bus.hours   = 5'($urandom_range(0, 23));
      bus.minutes = 6'($urandom_range(0, 59));
      bus.seconds = 6'($urandom_range(0, 59));
    end
  endtask

  // Monitor: one output word per clock, compared against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (bus.digit_sel !== e.dsel || bus.seg_out !== e.seg) begin
          bad++;
          $display("FAIL scan_out t=%0t dsel=%h seg=%h required dsel=%h seg=%h",
                   $time, bus.digit_sel, bus.seg_out, e.dsel, e.seg);
        end
      end
    end
  end

  initial begin
    int guard;
    bus.power_state = 1'b0;
    bus.set_mode    = 1'b0;
    bus.set_select  = 1'b0;
    bus.hours       = '0;
    bus.minutes     = '0;
    bus.seconds     = '0;
    #1 reset = 1'b0;
    #1;
    total++;
    if (bus.seg_out !== 8'h00 || bus.digit_sel !== 8'h00) begin
      bad++;
      $display("FAIL reset_state seg=%h dsel=%h required 00/00", bus.seg_out, bus.digit_sel);
    end
    @(negedge clk);
    cycle(3);

    reset = 1'b1;
    bus.power_state = 1'b1;
    cycle(40);

    bus.hours = 5'd23; bus.minutes = 6'd59; bus.seconds = 6'd58;
    cycle(70);

    bus.set_mode = 1'b1; bus.set_select = 1'b1;
    cycle(70);
    guard = 0;
    while (((run / BLINK) % 2) == 0 && guard < 64) begin
      cycle();
      guard++;
    end
    total++;
    if (guard >= 64) begin
      bad++;
      $display("FAIL blank_phase_reach guard=%0d required <64", guard);
    end
    bus.set_mode = 1'b0;
    cycle(20);

    bus.set_mode = 1'b1; bus.set_select = 1'b0;
    cycle(50);
    bus.set_mode = 1'b0;

    bus.hours = 5'd25;
    cycle(40);
    bus.hours = 5'd12; bus.minutes = 6'd63; bus.seconds = 6'd7;
    cycle(70);

    cycle(5);
    bus.power_state = 1'b0;
    cycle(5);
    bus.power_state = 1'b1;
    cycle(40);

    cycle(2);
    async_reset_check();
    cycle(2);
    reset = 1'b1;
    cycle(40);

    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 39) == 0) random_time();
      if ($urandom_range(0, 59) == 0) bus.set_mode = ~bus.set_mode;
      if ($urandom_range(0, 19) == 0) bus.set_select = 1'($urandom_range(0, 1));
      if (bus.power_state) begin
        if ($urandom_range(0, 299) == 0) bus.power_state = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        bus.power_state = 1'b1;
      end
      reset = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      cycle();
    end

    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
